// File: rtl/e203_dsat_clip_if.sv
// e203_dsat_clip_if: request/result bus of the SIMD saturating clip unit.
//   Request : i_valid, i_ready, i_op[31:0], i_esz[1:0], i_pos[4:0], i_uns
//   Result  : o_valid, o_ready, o_res[31:0], o_ov[3:0]
//   master  : requester side (drives request payload and o_ready)
//   slave   : clip unit side
interface e203_dsat_clip_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            i_ready;
  logic [XLEN-1:0] i_op;
  logic [1:0]      i_esz;
  logic [4:0]      i_pos;
  logic            i_uns;
  logic            o_valid;
  logic            o_ready;
  logic [XLEN-1:0] o_res;
  logic [3:0]      o_ov;

  modport master (
    output i_valid, i_op, i_esz, i_pos, i_uns, o_ready,
    input  i_ready, o_valid, o_res, o_ov
  );

  modport slave (
    input  i_valid, i_op, i_esz, i_pos, i_uns, o_ready,
    output i_ready, o_valid, o_res, o_ov
  );
endinterface

// File: rtl/e203_dsat_clip.sv
// e203_dsat_clip: two-stage pipelined SIMD saturating clip (CLIP8/16/32).
//   clk       : core clock
//   rst       : synchronous active-high reset
//   bus       : e203_dsat_clip_if slave (request/result valid-ready bus)
//               i_esz 0=8b x4, 1=16b x2, 2=32b x1, 3=reserved (passes through)
//               i_pos saturation position N, clamped to E-1 per element width
//               o_ov  per-byte-lane overflow flags of the result
//   ov_sticky : sticky OV CSR bit, set after an overflowing output handshake
//   ov_clr    : clear ov_sticky (a coincident set wins)
// Optional feature: define E203_DSAT_UNSIGNED_EN to enable unsigned clip
// (i_uns=1 clamps to [0, 2^N-1]); otherwise i_uns is ignored.
// Only XLEN = 32 is supported.
module e203_dsat_clip #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  e203_dsat_clip_if.slave   bus,
  output logic              ov_sticky,
  input  logic              ov_clr
);

  // ---------------- handshake ----------------
  logic s1_full;
  logic s2_adv;
  logic acc;

  assign s2_adv      = ~bus.o_valid | bus.o_ready;
  assign bus.i_ready = ~s1_full | s2_adv;
  assign acc         = bus.i_valid & bus.i_ready;

  // ---------------- S1: mask generation ----------------
  logic [31:0] mask_b_d;
  logic [2:0]  ne8;
  logic [3:0]  ne16;
  logic [7:0]  m8;
  logic [15:0] m16;

  // mask_b covers bits [E-2:Ne] of each element; empty when Ne = E-1.
  always_comb begin
    ne8      = (bus.i_pos > 5'd7)  ? 3'd7  : bus.i_pos[2:0];
    ne16     = (bus.i_pos > 5'd15) ? 4'd15 : bus.i_pos[3:0];
    m8       = (8'hFF << ne8) & 8'h7F;
    m16      = (16'hFFFF << ne16) & 16'h7FFF;
    mask_b_d = '0;
    unique case (bus.i_esz)
      2'd0:    mask_b_d = {4{m8}};
      2'd1:    mask_b_d = {2{m16}};
      2'd2:    mask_b_d = (32'hFFFF_FFFF << bus.i_pos) & 32'h7FFF_FFFF;
      default: mask_b_d = '0;  // reserved: behaves as 32-bit with Ne = 31
    endcase
  end

  logic [XLEN-1:0] s1_op;
  logic [1:0]      s1_esz;
  logic            s1_uns;
  logic [31:0]     s1_mask_b;
  logic [31:0]     s1_mask_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full   <= 1'b0;
      s1_op     <= '0;
      s1_esz    <= '0;
      s1_uns    <= 1'b0;
      s1_mask_b <= '0;
      s1_mask_t <= '1;
    end else begin
      if (acc)
        s1_full <= 1'b1;
      else if (s2_adv)
        s1_full <= 1'b0;
      if (acc) begin
        s1_op     <= bus.i_op;
        s1_esz    <= bus.i_esz;
`ifdef E203_DSAT_UNSIGNED_EN
        s1_uns    <= bus.i_uns;
`else
        s1_uns    <= 1'b0;
`endif
        s1_mask_b <= mask_b_d;
        s1_mask_t <= ~mask_b_d;
      end
    end
  end

  // ---------------- S2: overflow detect and clamp ----------------
  // Per-byte partial reductions are merged according to the element size,
  // and the element flags are replicated back onto every byte lane.
  logic [31:0] xm;
  logic [31:0] xf;
  logic [31:0] sgn_m;
  logic [31:0] lo;
  logic [31:0] res_d;
  logic [3:0]  hit;
  logic [3:0]  full;
  logic [3:0]  any_l;
  logic [3:0]  all_l;
  logic [3:0]  sgn_l;
  logic [3:0]  top_l;
  logic [3:0]  bot_l;
  logic [3:0]  ov_d;

  always_comb begin
    xm = s1_op & s1_mask_b;
    xf = xm | s1_mask_t;
    hit  = '0;
    full = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      hit[k]  = |xm[8*k +: 8];
      full[k] = &xf[8*k +: 8];
    end

    any_l = '0;
    all_l = '0;
    sgn_l = '0;
    sgn_m = '0;
    unique case (s1_esz)
      2'd0: begin
        any_l = hit;
        all_l = full;
        sgn_l = {s1_op[31], s1_op[23], s1_op[15], s1_op[7]};
        sgn_m = 32'h8080_8080;
      end
      2'd1: begin
        any_l = {{2{hit[3] | hit[2]}}, {2{hit[1] | hit[0]}}};
        all_l = {{2{full[3] & full[2]}}, {2{full[1] & full[0]}}};
        sgn_l = {{2{s1_op[31]}}, {2{s1_op[15]}}};
        sgn_m = 32'h8000_8000;
      end
      default: begin
        any_l = {4{|hit}};
        all_l = {4{&full}};
        sgn_l = {4{s1_op[31]}};
        sgn_m = 32'h8000_0000;
      end
    endcase

    top_l = ~sgn_l & any_l;
    bot_l = s1_uns ? sgn_l : (sgn_l & ~all_l);
    ov_d  = top_l | bot_l;

    // lo = 2^Ne - 1 per element; its complement is -2^Ne sign-extended.
    lo    = s1_mask_t & ~sgn_m;
    res_d = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (top_l[k])
        res_d[8*k +: 8] = lo[8*k +: 8];
      else if (bot_l[k])
        res_d[8*k +: 8] = s1_uns ? 8'h00 : ~lo[8*k +: 8];
      else
        res_d[8*k +: 8] = s1_op[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_valid <= 1'b0;
      bus.o_res   <= '0;
      bus.o_ov    <= '0;
    end else if (s2_adv) begin
      bus.o_valid <= s1_full;
      if (s1_full) begin
        bus.o_res <= res_d;
        bus.o_ov  <= ov_d;
      end
    end
  end

  // ---------------- sticky OV ----------------
  always_ff @(posedge clk) begin
    if (rst)
      ov_sticky <= 1'b0;
    else if (bus.o_valid & bus.o_ready & (|bus.o_ov))
      ov_sticky <= 1'b1;
    else if (ov_clr)
      ov_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_e203_dsat_clip.sv
// tb_e203_dsat_clip: directed self-checking bench for e203_dsat_clip.
module tb_e203_dsat_clip;

  logic clk;
  logic rst;
  logic ov_clr;
  logic ov_sticky;

  int n_tests;
  int n_fail;

  e203_dsat_clip_if #(.XLEN(32)) bus ();

  e203_dsat_clip #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ov_sticky (ov_sticky),
    .ov_clr    (ov_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with o_ready high; returns at the negedge where the
  // result is presented (handshake happens at the following posedge).
  task automatic run_one(input string tag, input logic [31:0] op, input logic [1:0] esz,
                         input logic [4:0] pos, input logic uns,
                         input logic [31:0] exp_res, input logic [3:0] exp_ov);
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_esz   = esz;
    bus.i_pos   = pos;
    bus.i_uns   = uns;
    #1;
    check({tag, "_iready"}, {31'd0, bus.i_ready}, 32'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    check({tag, "_lat1"}, {31'd0, bus.o_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, bus.o_valid}, 32'd1);
    check({tag, "_res"}, bus.o_res, exp_res);
    check({tag, "_ov"}, {28'd0, bus.o_ov}, {28'd0, exp_ov});
  endtask

  logic [31:0] ops [4];
  int nacc;
  int nout;
  int acc_at_drop;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    ov_clr = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_op    = '0;
    bus.i_esz   = '0;
    bus.i_pos   = '0;
    bus.i_uns   = 1'b0;
    bus.o_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ovalid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_ores", bus.o_res, 32'd0);
    check("rst_oov", {28'd0, bus.o_ov}, 32'd0);
    check("rst_sticky", {31'd0, ov_sticky}, 32'd0);
    check("rst_iready", {31'd0, bus.i_ready}, 32'd1);

    // 8-bit signed, N=3: 0x7F->0x07 (top), 0x80->0xF8 (bottom), 0x05, 0xFB (-5) in range
    run_one("t8", 32'h7F80_05FB, 2'd0, 5'd3, 1'b0, 32'h07F8_05FB, 4'b1100);
    check("t8_sticky_pre", {31'd0, ov_sticky}, 32'd0);
    @(negedge clk);
    check("t8_sticky", {31'd0, ov_sticky}, 32'd1);
    check("t8_drained", {31'd0, bus.o_valid}, 32'd0);

    // 16-bit, N=15 = E-1: no saturation
    run_one("t16n", 32'h1234_FFFF, 2'd1, 5'd15, 1'b0, 32'h1234_FFFF, 4'b0000);
    @(negedge clk);
    check("t16n_sticky", {31'd0, ov_sticky}, 32'd1);

    // 8-bit with N=20 clamps to 7: passthrough
    run_one("t8big", 32'h80FF_7F01, 2'd0, 5'd20, 1'b0, 32'h80FF_7F01, 4'b0000);
    @(negedge clk);

    // 16-bit overflow both directions, N=7
    run_one("t16o", 32'h7FFF_8000, 2'd1, 5'd7, 1'b0, 32'h007F_FF80, 4'b1111);
    @(negedge clk);

    // Reserved esz behaves as 32-bit passthrough
    run_one("tesz3", 32'h8000_0001, 2'd3, 5'd4, 1'b0, 32'h8000_0001, 4'b0000);
    @(negedge clk);

    // ov_clr alone
    ov_clr = 1'b1;
    @(negedge clk);
    ov_clr = 1'b0;
    check("clr_alone", {31'd0, ov_sticky}, 32'd0);

    // 32-bit, N=7
    run_one("t32", 32'h8000_0000, 2'd2, 5'd7, 1'b0, 32'hFFFF_FF80, 4'b1111);
    check("t32_sticky_pre", {31'd0, ov_sticky}, 32'd0);
    @(negedge clk);
    check("t32_sticky", {31'd0, ov_sticky}, 32'd1);

    // Second overflowing handshake coincident with ov_clr: set wins
    run_one("t32b", 32'h7FFF_FFFF, 2'd2, 5'd30, 1'b0, 32'h3FFF_FFFF, 4'b1111);
    ov_clr = 1'b1;
    @(negedge clk);
    ov_clr = 1'b0;
    check("clr_vs_set", {31'd0, ov_sticky}, 32'd1);
    ov_clr = 1'b1;
    @(negedge clk);
    ov_clr = 1'b0;
    check("clr_after", {31'd0, ov_sticky}, 32'd0);

    // Unsigned select (effective only with the optional feature)
`ifdef E203_DSAT_UNSIGNED_EN
    run_one("tuns", 32'h8020_0AFF, 2'd0, 5'd4, 1'b1, 32'h000F_0A00, 4'b1101);
`else
    run_one("tuns", 32'h8020_0AFF, 2'd0, 5'd4, 1'b1, 32'hF00F_0AFF, 4'b1100);
`endif
    @(negedge clk);
    check("tuns_sticky", {31'd0, ov_sticky}, 32'd1);

    // Back-to-back stream with a 3-cycle output stall
    ops[0] = 32'h1122_3344;
    ops[1] = 32'h5566_7788;
    ops[2] = 32'h99AA_BBCC;
    ops[3] = 32'hDDEE_FF00;
    nacc = 0;
    nout = 0;
    acc_at_drop = -1;
    bus.i_esz = 2'd2;
    bus.i_pos = 5'd31;
    bus.i_uns = 1'b0;
    for (int c = 0; c < 40 && nout < 4; c++) begin
      bus.o_ready = !(c >= 2 && c <= 4);
      bus.i_valid = (nacc < 4);
      bus.i_op    = (nacc < 4) ? ops[nacc] : 32'd0;
      #1;
      if (!bus.i_ready && acc_at_drop < 0) acc_at_drop = nacc;
      if (bus.o_valid) begin
        check("b2b_res", bus.o_res, ops[nout]);
        check("b2b_ov", {28'd0, bus.o_ov}, 32'd0);
      end
      if (bus.o_valid && bus.o_ready) nout++;
      if (bus.i_valid && bus.i_ready) nacc++;
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    check("b2b_nout", nout, 32'd4);
    check("b2b_nacc", nacc, 32'd4);
    check("b2b_drop", acc_at_drop, 32'd2);
    check("b2b_nodup", {31'd0, bus.o_valid}, 32'd0);
    @(negedge clk);
    check("b2b_nodup2", {31'd0, bus.o_valid}, 32'd0);

    // Reset with both stages full and sticky set
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_op    = 32'h7F80_05FB;
    bus.i_esz   = 2'd0;
    bus.i_pos   = 5'd3;
    @(negedge clk);
    @(negedge clk);
    check("full_ovalid", {31'd0, bus.o_valid}, 32'd1);
    check("full_iready", {31'd0, bus.i_ready}, 32'd0);
    check("full_sticky", {31'd0, ov_sticky}, 32'd1);
    bus.i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ovalid", {31'd0, bus.o_valid}, 32'd0);
    check("mrst_iready", {31'd0, bus.i_ready}, 32'd1);
    check("mrst_sticky", {31'd0, ov_sticky}, 32'd0);
    check("mrst_ores", bus.o_res, 32'd0);
    bus.o_ready = 1'b1;
    @(negedge clk);
    check("mrst_flush1", {31'd0, bus.o_valid}, 32'd0);
    @(negedge clk);
    check("mrst_flush2", {31'd0, bus.o_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
